uart_mem_responder: RTL and testbench

//  Memory-side responder for the MMU m_* request interface. Each read/write request is

---
 rtl/uart_mem_responder_pkg.sv | 54 +++++
 rtl/uart_mem_responder_if.sv | 31 +++
 rtl/uart_mem_responder_rx_timer.sv | 30 +++
 rtl/uart_mem_responder.sv | 175 +++++++++++++++++
 tb/tb_uart_mem_responder.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_mem_responder_pkg.sv
// Shared definitions for the UART memory responder.
//  - Bus widths that match the MMU request interface (address, data, length).
//  - Command byte layout: op flag in bit 7, length-1 in the low bits.
//  - Byte the host returns to confirm a write.
//  - FSM state encodings and small helpers for building frame bytes.
package uart_mem_responder_pkg;

  localparam int M_ADDR_W   = 32;
  localparam int C_DATA_W   = 32;
  localparam int RW_LEN_W   = 2;

  localparam int CMD_OP_BIT = 7;  // 1 = write, 0 = read
  localparam logic [7:0] UART_WACK_BYTE = 8'hA5;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CMD     = 3'd1,
    ST_ADDR    = 3'd2,
    ST_WDATA   = 3'd3,
    ST_WAIT_RX = 3'd4,
    ST_ACK     = 3'd5
  } state_t;

  function automatic logic is_tx_state(input state_t s);
    return (s == ST_CMD) || (s == ST_ADDR) || (s == ST_WDATA);
  endfunction

  // Byte presented to the UART for a given transmit state and byte index.
  // Address goes out MSB first, write data LSB first.
  function automatic logic [7:0] frame_byte(
    input state_t                s,
    input logic [1:0]            idx,
    input logic                  op,
    input logic [RW_LEN_W-1:0]   len,
    input logic [M_ADDR_W-1:0]   addr,
    input logic [C_DATA_W-1:0]   wdata
  );
    logic [7:0] b;
    logic [1:0] lane;
    b    = 8'h00;
    lane = 2'd3 - idx;
    case (s)
      ST_CMD: begin
        b[CMD_OP_BIT]   = op;
        b[RW_LEN_W-1:0] = len;
      end
      ST_ADDR:  b = addr[{lane, 3'b000} +: 8];
      ST_WDATA: b = wdata[{idx, 3'b000} +: 8];
      default:  b = 8'h00;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/uart_mem_responder_if.sv
// MMU memory request bus.
//  master : MMU side (drives requests, receives acks and read data)
//  slave  : memory responder side
//  m_re/m_we      level requests, held until the matching ack
//  m_raddr/m_waddr, m_rlen/m_wlen (length-1), m_wdata (byte0 = [7:0])
//  m_rdata        read data, valid while m_rack
//  m_rack/m_wack  4-phase acks
interface uart_mem_responder_if;
  import uart_mem_responder_pkg::*;

  logic                m_re;
  logic                m_we;
  logic [M_ADDR_W-1:0] m_raddr;
  logic [M_ADDR_W-1:0] m_waddr;
  logic [RW_LEN_W-1:0] m_rlen;
  logic [RW_LEN_W-1:0] m_wlen;
  logic [C_DATA_W-1:0] m_wdata;
  logic [C_DATA_W-1:0] m_rdata;
  logic                m_rack;
  logic                m_wack;

  modport master (
    output m_re, m_we, m_raddr, m_waddr, m_rlen, m_wlen, m_wdata,
    input  m_rdata, m_rack, m_wack
  );

  modport slave (
    input  m_re, m_we, m_raddr, m_waddr, m_rlen, m_wlen, m_wdata,
    output m_rdata, m_rack, m_wack
  );
endinterface

// File: rtl/uart_mem_responder_rx_timer.sv
// uart_rx_timer: inter-byte receive timer.
//  clk, rst : clock, asynchronous active-high reset
//  clr      : restart counting from zero (held while the timer is idle)
//  tc       : high while the count sits at COUNT-1 and clr is low
// The count saturates at COUNT-1; the owner leaves its waiting state on tc.
module uart_rx_timer #(
  parameter int COUNT = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tc
);
  localparam int CNT_W = (COUNT > 2) ? $clog2(COUNT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(COUNT - 1);

  logic [CNT_W-1:0] count_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg <= '0;
    end else if (clr) begin
      count_reg <= '0;
    end else if (count_reg != LAST) begin
      count_reg <= count_reg + CNT_W'(1);
    end
  end

  assign tc = !clr && (count_reg == LAST);
endmodule

// File: rtl/uart_mem_responder.sv
// uart_mem_responder: serves MMU read/write requests by framing them to a
// host over a UART byte core and returning the host reply.
//  clk, rst            clock, asynchronous active-high reset
//  mem (slave)         MMU request bus with 4-phase acks
//  tx_data/tx_valid    byte to UART core, held until tx_ready
//  tx_ready            UART core accepts on tx_valid & tx_ready
//  rx_data/rx_valid    received byte, one-cycle strobe
//  err                 one-cycle pulse on reply timeout or bad write-ack byte
// Frame: CMD {op,5'b0,len}, 4 address bytes MSB first, write data LSB first.
// Reply: read -> len+1 bytes LSB first; write -> one confirm byte.
module uart_mem_responder
  import uart_mem_responder_pkg::*;
#(
  parameter int         TIMEOUT = 50000,
  parameter logic [7:0] WACK_B  = UART_WACK_BYTE
) (
  input  logic                 clk,
  input  logic                 rst,
  uart_mem_responder_if.slave  mem,
  output logic [7:0]           tx_data,
  output logic                 tx_valid,
  input  logic                 tx_ready,
  input  logic [7:0]           rx_data,
  input  logic                 rx_valid,
  output logic                 err
);
  state_t              state_reg, state_next;
  logic [1:0]          idx_reg, idx_next;
  logic                is_write_reg, is_write_next;
  logic [M_ADDR_W-1:0] addr_reg, addr_next;
  logic [RW_LEN_W-1:0] len_reg, len_next;
  logic [C_DATA_W-1:0] wdata_reg, wdata_next;
  logic [C_DATA_W-1:0] rdata_reg, rdata_next;
  logic [7:0]          tx_data_reg, tx_data_next;
  logic                tx_valid_reg, tx_valid_next;
  logic                rack_reg, rack_next;
  logic                wack_reg, wack_next;
  logic                err_reg, err_next;

  logic tx_hs;
  logic req_held;
  logic timer_clr;
  logic timer_tc;

  assign tx_hs     = tx_valid_reg & tx_ready;
  assign req_held  = is_write_reg ? mem.m_we : mem.m_re;
  // Timer runs only while waiting for the host; every received byte restarts it.
  assign timer_clr = (state_reg != ST_WAIT_RX) || rx_valid;

  uart_rx_timer #(.COUNT(TIMEOUT)) u_rx_timer (
    .clk (clk),
    .rst (rst),
    .clr (timer_clr),
    .tc  (timer_tc)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= ST_IDLE;
    else     state_reg <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:    if (mem.m_re || mem.m_we) state_next = ST_CMD;
      ST_CMD:     if (tx_hs) state_next = ST_ADDR;
      ST_ADDR:    if (tx_hs && idx_reg == 2'd3)
                    state_next = is_write_reg ? ST_WDATA : ST_WAIT_RX;
      ST_WDATA:   if (tx_hs && idx_reg == len_reg) state_next = ST_WAIT_RX;
      ST_WAIT_RX: begin
        if (rx_valid) begin
          if (is_write_reg || idx_reg == len_reg) state_next = ST_ACK;
        end else if (timer_tc) begin
          state_next = ST_ACK;
        end
      end
      // Ack drops on the edge after the request is seen low; IDLE only
      // looks at requests from the following cycle on.
      ST_ACK:     if (!req_held) state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
  end

  // Output / datapath next values
  always_comb begin
    idx_next      = idx_reg;
    is_write_next = is_write_reg;
    addr_next     = addr_reg;
    len_next      = len_reg;
    wdata_next    = wdata_reg;
    rdata_next    = rdata_reg;
    err_next      = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        idx_next = 2'd0;
        // Read wins a same-cycle collision; the write stays pending.
        if (mem.m_re) begin
          is_write_next = 1'b0;
          addr_next     = mem.m_raddr;
          len_next      = mem.m_rlen;
          rdata_next    = '0;
        end else if (mem.m_we) begin
          is_write_next = 1'b1;
          addr_next     = mem.m_waddr;
          len_next      = mem.m_wlen;
          wdata_next    = mem.m_wdata;
          rdata_next    = '0;
        end
      end
      ST_CMD:   idx_next = 2'd0;
      ST_ADDR:  if (tx_hs) idx_next = idx_reg + 2'd1;  // wraps 3 -> 0 for the next phase
      ST_WDATA: if (tx_hs) idx_next = (idx_reg == len_reg) ? 2'd0 : idx_reg + 2'd1;
      ST_WAIT_RX: begin
        if (rx_valid) begin
          if (is_write_reg) begin
            if (rx_data != WACK_B) err_next = 1'b1;
          end else begin
            rdata_next[{idx_reg, 3'b000} +: 8] = rx_data;
            idx_next = idx_reg + 2'd1;
          end
        end else if (timer_tc) begin
          err_next   = 1'b1;
          rdata_next = '0;
        end
      end
      default: ;
    endcase

    rack_next     = (state_next == ST_ACK) && !is_write_next;
    wack_next     = (state_next == ST_ACK) &&  is_write_next;
    // Bytes only change on a handshake, so tx_data holds under backpressure.
    tx_valid_next = is_tx_state(state_next);
    tx_data_next  = tx_valid_next
                  ? frame_byte(state_next, idx_next, is_write_next, len_next, addr_next, wdata_next)
                  : 8'h00;
  end

  // Output / datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_reg      <= '0;
      is_write_reg <= 1'b0;
      addr_reg     <= '0;
      len_reg      <= '0;
      wdata_reg    <= '0;
      rdata_reg    <= '0;
      tx_data_reg  <= '0;
      tx_valid_reg <= 1'b0;
      rack_reg     <= 1'b0;
      wack_reg     <= 1'b0;
      err_reg      <= 1'b0;
    end else begin
      idx_reg      <= idx_next;
      is_write_reg <= is_write_next;
      addr_reg     <= addr_next;
      len_reg      <= len_next;
      wdata_reg    <= wdata_next;
      rdata_reg    <= rdata_next;
      tx_data_reg  <= tx_data_next;
      tx_valid_reg <= tx_valid_next;
      rack_reg     <= rack_next;
      wack_reg     <= wack_next;
      err_reg      <= err_next;
    end
  end

  assign tx_data     = tx_data_reg;
  assign tx_valid    = tx_valid_reg;
  assign err         = err_reg;
  assign mem.m_rdata = rdata_reg;
  assign mem.m_rack  = rack_reg;
  assign mem.m_wack  = wack_reg;
endmodule

// File: tb/tb_uart_mem_responder.sv
// Directed testbench for uart_mem_responder: table of read/write
// transactions plus hand sequences for collision, timeout, backpressure
// and reset mid-frame.
module tb_uart_mem_responder;
  import uart_mem_responder_pkg::*;

  localparam int TB_TIMEOUT = 40;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       err;

  uart_mem_responder_if mem_if();

  uart_mem_responder #(.TIMEOUT(TB_TIMEOUT), .WACK_B(8'hA5)) dut (
    .clk      (clk),
    .rst      (rst),
    .mem      (mem_if),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .err      (err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int err_total = 0;

  always @(negedge clk) if (err === 1'b1) err_total++;

  typedef struct {
    bit          is_wr;
    logic [31:0] addr;
    logic [1:0]  len;
    logic [31:0] wdata;
    logic [31:0] rx;      // reply bytes, byte k = rx[8k +: 8]
    int          n_rx;
    logic [71:0] tx;      // expected frame, byte k = tx[71-8k -: 8]
    int          n_tx;
    logic [31:0] exp_rdata;
    int          exp_err;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic get_tx(output logic [7:0] b, output bit ok);
    ok = 1'b0;
    b  = 8'h00;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (tx_valid && tx_ready) begin
        b  = tx_data;
        ok = 1'b1;
        break;
      end
    end
    if (ok) @(posedge clk);
  endtask

  task automatic send_rx(input logic [7:0] b);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic wait_ack(input bit is_wr, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (is_wr ? mem_if.m_wack : mem_if.m_rack) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic run_vec(input vec_t v, input int id);
    logic [7:0]  b;
    logic [71:0] t;
    bit          ok;
    int          e0;
    @(negedge clk);
    e0 = err_total;
    if (v.is_wr) begin
      mem_if.m_we = 1'b1; mem_if.m_waddr = v.addr; mem_if.m_wlen = v.len; mem_if.m_wdata = v.wdata;
    end else begin
      mem_if.m_re = 1'b1; mem_if.m_raddr = v.addr; mem_if.m_rlen = v.len;
    end
    t = v.tx;
    for (int k = 0; k < v.n_tx; k++) begin
      get_tx(b, ok);
      chk($sformatf("v%0d_tx%0d", id, k), ok ? {24'h0, b} : 32'hDEAD0000, {24'h0, t[71-8*k -: 8]});
    end
    for (int k = 0; k < v.n_rx; k++) send_rx(v.rx[8*k +: 8]);
    wait_ack(v.is_wr, ok);
    chk($sformatf("v%0d_ack", id), {31'h0, ok}, 32'h1);
    if (v.is_wr) begin
      chk($sformatf("v%0d_rack_off", id), {31'h0, mem_if.m_rack}, 32'h0);
    end else begin
      chk($sformatf("v%0d_rdata", id), mem_if.m_rdata, v.exp_rdata);
      chk($sformatf("v%0d_wack_off", id), {31'h0, mem_if.m_wack}, 32'h0);
    end
    mem_if.m_re = 1'b0;
    mem_if.m_we = 1'b0;
    @(negedge clk);
    chk($sformatf("v%0d_ack_drop", id), {30'h0, mem_if.m_rack, mem_if.m_wack}, 32'h0);
    chk($sformatf("v%0d_err", id), err_total - e0, v.exp_err);
    $display("txn %0d: %s addr=%h len=%0d rdata=%h errs=%0d", id, v.is_wr ? "write" : "read ",
             v.addr, v.len, mem_if.m_rdata, err_total - e0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] b;
    logic [7:0] cap;
    bit         ok;
    bit         stable;
    int         cnt;
    int         e0;

    vecs[0] = '{is_wr:1'b0, addr:32'h0000_1234, len:2'd3, wdata:32'h0, rx:32'h4433_2211, n_rx:4,
                tx:72'h03_00_00_12_34_00_00_00_00, n_tx:5, exp_rdata:32'h4433_2211, exp_err:0};
    vecs[1] = '{is_wr:1'b1, addr:32'h0000_0010, len:2'd1, wdata:32'h0000_BEEF, rx:32'h0000_00A5, n_rx:1,
                tx:72'h81_00_00_00_10_EF_BE_00_00, n_tx:7, exp_rdata:32'h0, exp_err:0};
    vecs[2] = '{is_wr:1'b0, addr:32'hDEAD_BEEF, len:2'd0, wdata:32'h0, rx:32'h0000_005A, n_rx:1,
                tx:72'h00_DE_AD_BE_EF_00_00_00_00, n_tx:5, exp_rdata:32'h0000_005A, exp_err:0};
    vecs[3] = '{is_wr:1'b1, addr:32'h0102_0304, len:2'd3, wdata:32'hCAFE_F00D, rx:32'h0000_00A5, n_rx:1,
                tx:72'h83_01_02_03_04_0D_F0_FE_CA, n_tx:9, exp_rdata:32'h0, exp_err:0};
    vecs[4] = '{is_wr:1'b1, addr:32'h0000_0020, len:2'd0, wdata:32'h0000_0077, rx:32'h0000_0000, n_rx:1,
                tx:72'h80_00_00_00_20_77_00_00_00, n_tx:6, exp_rdata:32'h0, exp_err:1};
    vecs[5] = '{is_wr:1'b0, addr:32'h8000_0000, len:2'd1, wdata:32'h0, rx:32'h0000_CDAB, n_rx:2,
                tx:72'h01_80_00_00_00_00_00_00_00, n_tx:5, exp_rdata:32'h0000_CDAB, exp_err:0};

    rst = 1'b1;
    tx_ready = 1'b1;
    rx_data = 8'h00;
    rx_valid = 1'b0;
    mem_if.m_re = 1'b0; mem_if.m_we = 1'b0;
    mem_if.m_raddr = '0; mem_if.m_waddr = '0;
    mem_if.m_rlen = '0; mem_if.m_wlen = '0; mem_if.m_wdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_tx_valid", {31'h0, tx_valid}, 32'h0);
    chk("rst_tx_data", {24'h0, tx_data}, 32'h0);
    chk("rst_acks", {30'h0, mem_if.m_rack, mem_if.m_wack}, 32'h0);
    chk("rst_rdata", mem_if.m_rdata, 32'h0);
    chk("rst_err", {31'h0, err}, 32'h0);
    rst = 1'b0;
    $display("reset released");

    // Stray received byte while idle is ignored.
    send_rx(8'h5A);
    @(negedge clk);
    chk("idle_rx_no_tx", {31'h0, tx_valid}, 32'h0);
    chk("idle_rx_no_ack", {30'h0, mem_if.m_rack, mem_if.m_wack}, 32'h0);
    $display("idle rx byte discarded");

    for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

    // Collision: read frame first, write only after m_rack falls.
    @(negedge clk);
    mem_if.m_re = 1'b1; mem_if.m_raddr = 32'h44; mem_if.m_rlen = 2'd0;
    mem_if.m_we = 1'b1; mem_if.m_waddr = 32'h55; mem_if.m_wlen = 2'd0; mem_if.m_wdata = 32'h66;
    for (int k = 0; k < 5; k++) begin
      get_tx(b, ok);
      if (k == 0) chk("col_rd_cmd", ok ? {24'h0, b} : 32'hDEAD0000, 32'h00);
      if (k == 4) chk("col_rd_addr", ok ? {24'h0, b} : 32'hDEAD0000, 32'h44);
    end
    send_rx(8'h9C);
    wait_ack(1'b0, ok);
    chk("col_rack", {31'h0, ok}, 32'h1);
    chk("col_rdata", mem_if.m_rdata, 32'h9C);
    chk("col_wack_off", {31'h0, mem_if.m_wack}, 32'h0);
    mem_if.m_re = 1'b0;
    @(negedge clk);
    chk("col_rack_drop", {31'h0, mem_if.m_rack}, 32'h0);
    chk("col_no_early_tx", {31'h0, tx_valid}, 32'h0);
    for (int k = 0; k < 6; k++) begin
      get_tx(b, ok);
      if (k == 0) chk("col_wr_cmd", ok ? {24'h0, b} : 32'hDEAD0000, 32'h80);
      if (k == 4) chk("col_wr_addr", ok ? {24'h0, b} : 32'hDEAD0000, 32'h55);
      if (k == 5) chk("col_wr_data", ok ? {24'h0, b} : 32'hDEAD0000, 32'h66);
    end
    send_rx(8'hA5);
    wait_ack(1'b1, ok);
    chk("col_wack", {31'h0, ok}, 32'h1);
    mem_if.m_we = 1'b0;
    @(negedge clk);
    chk("col_wack_drop", {31'h0, mem_if.m_wack}, 32'h0);
    $display("collision: read then write done");

    // Timeout: no host reply.
    @(negedge clk);
    mem_if.m_re = 1'b1; mem_if.m_raddr = 32'h99; mem_if.m_rlen = 2'd0;
    for (int k = 0; k < 5; k++) get_tx(b, ok);
    cnt = 0;
    e0 = err_total;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (err) break;
      cnt++;
    end
    chk("to_err", {31'h0, err}, 32'h1);
    chk("to_cycles", cnt, TB_TIMEOUT);
    chk("to_rack", {31'h0, mem_if.m_rack}, 32'h1);
    chk("to_rdata", mem_if.m_rdata, 32'h0);
    @(negedge clk);
    chk("to_err_pulse", {31'h0, err}, 32'h0);
    mem_if.m_re = 1'b0;
    @(negedge clk);
    chk("to_rack_drop", {31'h0, mem_if.m_rack}, 32'h0);
    $display("timeout after %0d cycles", cnt);

    // Backpressure, then reset during the address phase.
    @(negedge clk);
    tx_ready = 1'b0;
    mem_if.m_re = 1'b1; mem_if.m_raddr = 32'hA1B2_C3D4; mem_if.m_rlen = 2'd2;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (tx_valid) begin ok = 1'b1; break; end
    end
    cap = tx_data;
    chk("bp_valid", {31'h0, ok}, 32'h1);
    chk("bp_cmd", {24'h0, cap}, 32'h02);
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (!(tx_valid && tx_data == cap)) stable = 1'b0;
    end
    chk("bp_stable", {31'h0, stable}, 32'h1);
    tx_ready = 1'b1;
    get_tx(b, ok);
    chk("bp_addr0", ok ? {24'h0, b} : 32'hDEAD0000, 32'hA1);
    @(negedge clk);
    rst = 1'b1;
    mem_if.m_re = 1'b0;
    #1;
    chk("mid_rst_tx", {23'h0, tx_valid, tx_data}, 32'h0);
    chk("mid_rst_acks", {29'h0, err, mem_if.m_rack, mem_if.m_wack}, 32'h0);
    chk("mid_rst_rdata", mem_if.m_rdata, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    $display("backpressure and reset mid-frame done");

    run_vec(vecs[0], 6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
